// File: rtl/btn_debounce_oneshot.sv
// Push-button input stage: synchronizes a raw pin, debounces it and emits one-shot
// press / long-press pulses, a debounced level and a wrapping press counter.
module btn_debounce_oneshot #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       iExtBtn,
  output logic       oExtBtn,
  output logic       oLongBtn,
  output logic       oBtnLevel,
  output logic [7:0] oPressCnt
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  // Pin value seen while the button is released
  localparam logic PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  logic                sync1_r;
  logic                sync2_r;
  logic                pressed_s;
  state_t              state_r;
  state_t              state_s;
  logic [DB_W-1:0]     dbcnt_r;
  logic [DB_W-1:0]     dbcnt_s;
  logic [HOLD_W-1:0]   holdcnt_r;
  logic [HOLD_W-1:0]   holdcnt_s;
  logic                long_fired_r;
  logic                long_fired_s;
  logic                ext_r;
  logic                ext_s;
  logic                long_r;
  logic                long_s;
  logic                level_r;
  logic                level_s;
  logic [7:0]          cnt_r;
  logic [7:0]          cnt_s;

  // Two-flop synchronizer, parked at the released pin value during reset
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1_r <= PIN_IDLE;
      sync2_r <= PIN_IDLE;
    end else begin
      sync1_r <= iExtBtn;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = sync2_r ^ PIN_IDLE;

  // Debounce FSM next-state and registered-output logic
  always_comb begin
    state_s      = state_r;
    dbcnt_s      = dbcnt_r;
    holdcnt_s    = holdcnt_r;
    long_fired_s = long_fired_r;
    ext_s        = 1'b0;
    long_s       = 1'b0;
    level_s      = level_r;
    cnt_s        = cnt_r;
    case (state_r)
      IDLE: begin
        if (pressed_s) begin
          state_s = DB_PRESS;
          dbcnt_s = DB_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      DB_PRESS: begin
        if (!pressed_s) begin
          state_s = IDLE;
        end else if (dbcnt_r == DB_LAST) begin
          state_s      = HELD;
          ext_s        = 1'b1;
          level_s      = 1'b1;
          cnt_s        = cnt_r + 8'd1;
          holdcnt_s    = HOLD_ZERO;
          long_fired_s = 1'b0;
        end else begin
          dbcnt_s = dbcnt_r + DB_ONE;
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_s = DB_RELEASE;
          dbcnt_s = DB_ZERO;
        end else begin
          if ((holdcnt_r == HOLD_LAST) && !long_fired_r) begin
            long_s       = 1'b1;
            long_fired_s = 1'b1;
          end else begin
            long_s = 1'b0;
          end
          // Saturate so the long pulse can only be armed once per press
          if (holdcnt_r < HOLD_LAST) begin
            holdcnt_s = holdcnt_r + HOLD_ONE;
          end else begin
            holdcnt_s = holdcnt_r;
          end
        end
      end
      DB_RELEASE: begin
        if (pressed_s) begin
          state_s = HELD;
        end else if (dbcnt_r == DB_LAST) begin
          state_s = IDLE;
          level_s = 1'b0;
        end else begin
          dbcnt_s = dbcnt_r + DB_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r      <= IDLE;
      dbcnt_r      <= DB_ZERO;
      holdcnt_r    <= HOLD_ZERO;
      long_fired_r <= 1'b0;
      ext_r        <= 1'b0;
      long_r       <= 1'b0;
      level_r      <= 1'b0;
      cnt_r        <= 8'd0;
    end else begin
      state_r      <= state_s;
      dbcnt_r      <= dbcnt_s;
      holdcnt_r    <= holdcnt_s;
      long_fired_r <= long_fired_s;
      ext_r        <= ext_s;
      long_r       <= long_s;
      level_r      <= level_s;
      cnt_r        <= cnt_s;
    end
  end

  assign oExtBtn   = ext_r;
  assign oLongBtn  = long_r;
  assign oBtnLevel = level_r;
  assign oPressCnt = cnt_r;

endmodule

// File: tb/tb_btn_debounce_oneshot.sv
// Self-checking bench for btn_debounce_oneshot: an active-high and an active-low
// instance share stimulus (inverted for the latter) and one run-length reference model.
module tb_btn_debounce_oneshot;

  localparam int D = 4;
  localparam int L = 10;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       btn = 1'b0;
  logic       btn_n = 1'b1;
  logic       ext_a, long_a, lvl_a;
  logic [7:0] cnt_a;
  logic       ext_b, long_b, lvl_b;
  logic [7:0] cnt_b;

  always #5 CLK = ~CLK;

  btn_debounce_oneshot #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(0)) dut_a (
    .CLK(CLK), .RESETn(RESETn), .iExtBtn(btn),
    .oExtBtn(ext_a), .oLongBtn(long_a), .oBtnLevel(lvl_a), .oPressCnt(cnt_a));

  btn_debounce_oneshot #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1)) dut_b (
    .CLK(CLK), .RESETn(RESETn), .iExtBtn(btn_n),
    .oExtBtn(ext_b), .oLongBtn(long_b), .oBtnLevel(lvl_b), .oPressCnt(cnt_b));

  typedef struct packed {
    logic       ext;
    logic       lng;
    logic       lvl;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    logic btn;
    int   cycles;
    int   ext_at;
    int   long_at;
    int   lvl_at;
    int   ext_tot;
    int   long_tot;
    int   cnt;
    logic lvl;
  } vec_t;

  obs_t sb_q[$];
  vec_t tbl[12];
  int   n_vec = 0;
  int   n_miss = 0;
  int   obs_ext = 0;
  int   obs_long = 0;

  // Reference model state: level flips after D+1 consecutive opposing samples
  logic       m_r1, m_r2, m_lvl, m_fired, m_prev;
  int         m_run, m_hold;
  logic [7:0] m_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_r1 = 1'b0; m_r2 = 1'b0; m_lvl = 1'b0; m_fired = 1'b0; m_prev = 1'b0;
    m_run = 0; m_hold = 0; m_cnt = 8'd0;
  endtask

  task automatic model_edge(input logic raw);
    obs_t e;
    logic v;
    v = m_r2;
    m_r2 = m_r1;
    m_r1 = raw;
    e.ext = 1'b0;
    e.lng = 1'b0;
    if (v != m_lvl) m_run++;
    else m_run = 0;
    if (m_run == D + 1) begin
      m_lvl = v;
      m_run = 0;
      if (v) begin
        e.ext = 1'b1;
        m_cnt = m_cnt + 8'd1;
        m_hold = 0;
        m_fired = 1'b0;
      end
    end else if (m_lvl && v && m_prev) begin
      m_hold++;
      if (m_hold == L && !m_fired) begin
        e.lng = 1'b1;
        m_fired = 1'b1;
      end
    end
    m_prev = v;
    e.lvl = m_lvl;
    e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  // One clock: drive at the negedge, model the posedge, compare at the next negedge
  task automatic step(input logic b);
    obs_t e;
    btn = b;
    btn_n = ~b;
    @(posedge CLK);
    model_edge(b);
    @(negedge CLK);
    e = sb_q.pop_front();
    check("cycle_a", int'({ext_a, long_a, lvl_a, cnt_a}), int'(e));
    check("cycle_b", int'({ext_b, long_b, lvl_b, cnt_b}), int'(e));
    if (ext_a) obs_ext++;
    if (long_a) obs_long++;
  endtask

  task automatic check_zero(input string name);
    check({name, "_a"}, int'({ext_a, long_a, lvl_a, cnt_a}), 0);
    check({name, "_b"}, int'({ext_b, long_b, lvl_b, cnt_b}), 0);
  endtask

  // Assert reset at the current negedge for two cycles; outputs must be cleared at once
  task automatic do_reset(input string name);
    RESETn = 1'b0;
    #1;
    check_zero({name, "_async"});
    @(negedge CLK);
    check_zero({name, "_hold1"});
    @(negedge CLK);
    check_zero({name, "_hold2"});
    RESETn = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ext_at, long_at, lvl_at;
    logic lvl_prev;
    int   idx;

    tbl[0]  = '{1'b1, 30,  6, 16,  6, 1, 1, 1, 1'b1};
    tbl[1]  = '{1'b0, 12, -1, -1,  6, 1, 1, 1, 1'b0};
    tbl[2]  = '{1'b1,  2, -1, -1, -1, 1, 1, 1, 1'b0};
    tbl[3]  = '{1'b0,  1, -1, -1, -1, 1, 1, 1, 1'b0};
    tbl[4]  = '{1'b1, 12,  6, -1,  6, 2, 1, 2, 1'b1};
    tbl[5]  = '{1'b0, 12, -1, -1,  6, 2, 1, 2, 1'b0};
    tbl[6]  = '{1'b1,  3, -1, -1, -1, 2, 1, 2, 1'b0};
    tbl[7]  = '{1'b0, 10, -1, -1, -1, 2, 1, 2, 1'b0};
    tbl[8]  = '{1'b1, 12,  6, -1,  6, 3, 1, 3, 1'b1};
    tbl[9]  = '{1'b0,  2, -1, -1, -1, 3, 1, 3, 1'b1};
    tbl[10] = '{1'b1, 20, -1,  5, -1, 3, 2, 3, 1'b1};
    tbl[11] = '{1'b0, 12, -1, -1,  6, 3, 2, 3, 1'b0};

    model_reset();
    #1;
    check_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    check_zero("reset_late");
    RESETn = 1'b1;

    // Scenarios 1-4 as segment vectors
    for (int s = 0; s < 12; s++) begin
      ext_at = -1; long_at = -1; lvl_at = -1;
      lvl_prev = lvl_a;
      for (int i = 0; i < tbl[s].cycles; i++) begin
        step(tbl[s].btn);
        if (ext_a && ext_at < 0) ext_at = i;
        if (long_a && long_at < 0) long_at = i;
        if (lvl_a != lvl_prev && lvl_at < 0) lvl_at = i;
        lvl_prev = lvl_a;
      end
      check($sformatf("seg%0d_ext_at", s), ext_at, tbl[s].ext_at);
      check($sformatf("seg%0d_long_at", s), long_at, tbl[s].long_at);
      check($sformatf("seg%0d_lvl_at", s), lvl_at, tbl[s].lvl_at);
      check($sformatf("seg%0d_ext_tot", s), obs_ext, tbl[s].ext_tot);
      check($sformatf("seg%0d_long_tot", s), obs_long, tbl[s].long_tot);
      check($sformatf("seg%0d_cnt", s), int'(cnt_a), tbl[s].cnt);
      check($sformatf("seg%0d_lvl", s), int'(lvl_a), int'(tbl[s].lvl));
    end

    // Scenario 5: 256 presses from reset wrap the counter to zero
    do_reset("rst5");
    obs_ext = 0;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 8; i++) step(1'b1);
      for (int i = 0; i < 8; i++) step(1'b0);
      if (p == 254) begin
        check("cnt_255_a", int'(cnt_a), 255);
        check("cnt_255_b", int'(cnt_b), 255);
      end
    end
    check("wrap_pulses", obs_ext, 256);
    check("wrap_cnt_a", int'(cnt_a), 0);
    check("wrap_cnt_b", int'(cnt_b), 0);

    // Scenario 6: reset while held, exactly on the in-flight press pulse
    idx = -1;
    for (int i = 0; i < 20 && idx < 0; i++) begin
      step(1'b1);
      if (ext_a) idx = i;
    end
    check("pre_reset_ext_at", idx, 6);
    check("pre_reset_cnt", int'(cnt_a), 1);
    do_reset("rst6");
    idx = -1;
    for (int i = 0; i < 20 && idx < 0; i++) begin
      step(1'b1);
      if (ext_a) idx = i;
    end
    check("post_reset_ext_at", idx, 6);
    check("post_reset_cnt_a", int'(cnt_a), 1);
    check("post_reset_cnt_b", int'(cnt_b), 1);
    for (int i = 0; i < 12; i++) step(1'b0);
    check("final_lvl", int'(lvl_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
